// File: rtl/fir_mac_seq.sv
// Control sequencer for a time-multiplexed FIR multiply-accumulate datapath.
// Define FIR_SEQ_PEND_EN to add a one-deep pending-sample latch.
`timescale 1ns/1ps
module fir_mac_seq #(
  parameter int unsigned NTAPS   = 64,
  parameter int unsigned MAC_LAT = 3
) (
  input  logic       clk_fast,
  input  logic       rst_n,
  input  logic       sample_stb,
  input  logic       cfg_req,
  input  logic [5:0] cfg_addr,
  input  logic       ovr_clr,
  output logic       cfg_grant,
  output logic       cmem_we,
  output logic [5:0] cmem_addr,
  output logic       dmem_we,
  output logic [5:0] dmem_waddr,
  output logic [5:0] dmem_raddr,
  output logic       acc_clr,
  output logic       mac_en,
  output logic       dout_valid,
  output logic       busy,
  output logic       overrun
);

  localparam int unsigned AW = 6;
  localparam int unsigned CW = 8;
  localparam logic [AW-1:0] AMASK   = AW'(NTAPS - 1);
  localparam logic [CW-1:0] MAC_END = CW'(NTAPS - 1);
  localparam logic [CW-1:0] DRN_END = CW'(MAC_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] wr_ptr, wr_ptr_nxt;
  logic          pending, pending_nxt;
  logic          overrun_nxt;
  logic          lost;

  logic          cfg_grant_d, cmem_we_d, dmem_we_d, acc_clr_d, mac_en_d;
  logic          dout_valid_d, busy_d;
  logic [AW-1:0] cmem_addr_d, dmem_waddr_d, dmem_raddr_d;

  // State and output registers; outputs are precomputed from the next state
  always_ff @(posedge clk_fast or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wr_ptr     <= '0;
      pending    <= 1'b0;
      overrun    <= 1'b0;
      cfg_grant  <= 1'b0;
      cmem_we    <= 1'b0;
      cmem_addr  <= '0;
      dmem_we    <= 1'b0;
      dmem_waddr <= '0;
      dmem_raddr <= '0;
      acc_clr    <= 1'b0;
      mac_en     <= 1'b0;
      dout_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      wr_ptr     <= wr_ptr_nxt;
      pending    <= pending_nxt;
      overrun    <= overrun_nxt;
      cfg_grant  <= cfg_grant_d;
      cmem_we    <= cmem_we_d;
      cmem_addr  <= cmem_addr_d;
      dmem_we    <= dmem_we_d;
      dmem_waddr <= dmem_waddr_d;
      dmem_raddr <= dmem_raddr_d;
      acc_clr    <= acc_clr_d;
      mac_en     <= mac_en_d;
      dout_valid <= dout_valid_d;
      busy       <= busy_d;
    end
  end

  // Next-state, counters, sample bookkeeping and next output values
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    wr_ptr_nxt  = wr_ptr;
    pending_nxt = pending;
    overrun_nxt = overrun & ~ovr_clr;
    lost        = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (sample_stb || pending) begin
          state_nxt   = S_LOAD;
          pending_nxt = 1'b0;
        end
      end
      S_LOAD: begin
        state_nxt = S_MAC;
        cnt_nxt   = '0;
      end
      S_MAC: begin
        if (cnt == MAC_END) begin
          state_nxt = S_DRAIN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DRAIN: begin
        if (cnt == DRN_END) begin
          state_nxt = S_DONE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_DONE: begin
        wr_ptr_nxt = (wr_ptr + AW'(1)) & AMASK;
        state_nxt  = S_IDLE;
`ifdef FIR_SEQ_PEND_EN
        if (pending) begin
          state_nxt   = S_LOAD;
          pending_nxt = 1'b0;
        end
`endif
      end
      default: state_nxt = S_IDLE;
    endcase

    // A strobe that cannot be sequenced right now
    if (sample_stb && (state != S_IDLE)) begin
`ifdef FIR_SEQ_PEND_EN
      if (!pending) begin
        if (state == S_DONE) state_nxt = S_LOAD;
        else                 pending_nxt = 1'b1;
      end else begin
        lost = 1'b1;
      end
`else
      lost = 1'b1;
`endif
    end
    if (lost) overrun_nxt = 1'b1;

    // Coefficient writes only while staying idle, at most every other cycle
    cfg_grant_d  = (state_nxt == S_IDLE) && cfg_req && !cfg_grant;
    cmem_we_d    = cfg_grant_d;
    cmem_addr_d  = '0;
    dmem_we_d    = (state_nxt == S_LOAD);
    acc_clr_d    = (state_nxt == S_LOAD);
    dmem_waddr_d = '0;
    mac_en_d     = (state_nxt == S_MAC);
    dmem_raddr_d = '0;
    dout_valid_d = (state_nxt == S_DONE);
    busy_d       = (state_nxt != S_IDLE);

    if (cfg_grant_d)             cmem_addr_d  = cfg_addr;
    else if (state_nxt == S_MAC) cmem_addr_d  = AW'(cnt_nxt) & AMASK;
    if (state_nxt == S_LOAD)     dmem_waddr_d = wr_ptr_nxt;
    if (state_nxt == S_MAC)      dmem_raddr_d = (wr_ptr_nxt - AW'(cnt_nxt)) & AMASK;
  end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed and randomized bench for fir_mac_seq against a per-sample timing model.
`timescale 1ns/1ps
module tb_fir_mac_seq;

  localparam int NTAPS   = 64;
  localparam int MAC_LAT = 3;
  localparam int LAT     = NTAPS + MAC_LAT + 2;

  logic       clk_fast = 1'b0;
  logic       rst_n, sample_stb, cfg_req, ovr_clr;
  logic [5:0] cfg_addr;
  logic       cfg_grant, cmem_we, dmem_we, acc_clr, mac_en, dout_valid, busy, overrun;
  logic [5:0] cmem_addr, dmem_waddr, dmem_raddr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_ptr = 0;
  bit exp_ovr = 1'b0;

  fir_mac_seq #(.NTAPS(NTAPS), .MAC_LAT(MAC_LAT)) dut (
    .clk_fast(clk_fast), .rst_n(rst_n), .sample_stb(sample_stb), .cfg_req(cfg_req),
    .cfg_addr(cfg_addr), .ovr_clr(ovr_clr), .cfg_grant(cfg_grant), .cmem_we(cmem_we),
    .cmem_addr(cmem_addr), .dmem_we(dmem_we), .dmem_waddr(dmem_waddr),
    .dmem_raddr(dmem_raddr), .acc_clr(acc_clr), .mac_en(mac_en),
    .dout_valid(dout_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk_fast = ~clk_fast;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_fast);
    #1;
    cyc++;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".grant"}, 32'(cfg_grant), 32'(0));
    chk({tag, ".cmem_we"}, 32'(cmem_we), 32'(0));
    chk({tag, ".cmem_addr"}, 32'(cmem_addr), 32'(0));
    chk({tag, ".dmem_we"}, 32'(dmem_we), 32'(0));
    chk({tag, ".waddr"}, 32'(dmem_waddr), 32'(0));
    chk({tag, ".raddr"}, 32'(dmem_raddr), 32'(0));
    chk({tag, ".acc_clr"}, 32'(acc_clr), 32'(0));
    chk({tag, ".mac_en"}, 32'(mac_en), 32'(0));
    chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(0));
    chk({tag, ".busy"}, 32'(busy), 32'(0));
    chk({tag, ".overrun"}, 32'(overrun), 32'(0));
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) begin
      tick();
      chk("idle.busy", 32'(busy), 32'(0));
      chk("idle.dout_valid", 32'(dout_valid), 32'(0));
      chk("idle.mac_en", 32'(mac_en), 32'(0));
      chk("idle.overrun", 32'(overrun), 32'(exp_ovr));
    end
  endtask

  // Follows one accepted sample from LOAD to DONE; extra strobes at offsets inj1/inj2
  task automatic follow(input int inj1, input int inj2, input int abort_at, output bit chain);
    bit set_o, clr_o;
    int k, exp_raddr;
    chain = 1'b0;
    set_o = 1'b0;
    clr_o = 1'b0;
    for (int i = 1; i <= LAT; i++) begin
      tick();
      sample_stb = 1'b0;
      ovr_clr    = 1'b0;
      if (set_o) exp_ovr = 1'b1;
      else if (clr_o) exp_ovr = 1'b0;
      set_o = 1'b0;
      clr_o = 1'b0;
      k = i - 2;
      exp_raddr = (i >= 2 && i <= NTAPS + 1) ? (((model_ptr - k) % NTAPS) + NTAPS) % NTAPS : 0;
      chk("seq.dmem_we", 32'(dmem_we), 32'(i == 1));
      chk("seq.acc_clr", 32'(acc_clr), 32'(i == 1));
      chk("seq.waddr", 32'(dmem_waddr), (i == 1) ? 32'(model_ptr) : 32'(0));
      chk("seq.mac_en", 32'(mac_en), 32'(i >= 2 && i <= NTAPS + 1));
      chk("seq.cmem_addr", 32'(cmem_addr), (i >= 2 && i <= NTAPS + 1) ? 32'(k) : 32'(0));
      chk("seq.raddr", 32'(dmem_raddr), 32'(exp_raddr));
      chk("seq.dout_valid", 32'(dout_valid), 32'(i == LAT));
      chk("seq.busy", 32'(busy), 32'(1));
      chk("seq.grant", 32'(cfg_grant), 32'(0));
      chk("seq.overrun", 32'(overrun), 32'(exp_ovr));
      if (i == abort_at) begin
        rst_n = 1'b0;
        #2;
        exp_ovr = 1'b0;
        check_all_zero("abort");
        model_ptr = 0;
        return;
      end
      if (i == inj1 || i == inj2) begin
        sample_stb = 1'b1;
`ifdef FIR_SEQ_PEND_EN
        if (!chain) chain = 1'b1;
        else set_o = 1'b1;
`else
        set_o = 1'b1;
`endif
      end
      if (i == inj2) begin
        ovr_clr = 1'b1;
        clr_o = 1'b1;
      end
    end
    model_ptr = (model_ptr + 1) % NTAPS;
  endtask

  task automatic cfg_write(input logic [5:0] a);
    cfg_req = 1'b1;
    cfg_addr = a;
    tick();
    cfg_req = 1'b0;
    chk("cfg.grant", 32'(cfg_grant), 32'(1));
    chk("cfg.cmem_we", 32'(cmem_we), 32'(1));
    chk("cfg.cmem_addr", 32'(cmem_addr), 32'(a));
    tick();
    chk("cfg.grant_off", 32'(cfg_grant), 32'(0));
    chk("cfg.addr_off", 32'(cmem_addr), 32'(0));
  endtask

  initial begin
    bit ch, ch2;
    logic [5:0] ra;
    rst_n = 1'b0;
    sample_stb = 1'b0;
    cfg_req = 1'b0;
    cfg_addr = '0;
    ovr_clr = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    cyc = 0;

    // single sample at cycle 10, then two more 256 cycles apart
    idle(10);
    sample_stb = 1'b1;
    follow(0, 0, 0, ch);
    for (int s = 0; s < 2; s++) begin
      idle(256 - LAT);
      sample_stb = 1'b1;
      follow(0, 0, 0, ch);
    end

    // idle coefficient writes, including a held request
    idle(3);
    cfg_write(6'h15);
    cfg_req = 1'b1;
    cfg_addr = 6'h07;
    for (int j = 0; j < 4; j++) begin
      tick();
      chk("cfg.hold_grant", 32'(cfg_grant), 32'(j % 2 == 0));
    end
    cfg_req = 1'b0;
    tick();
    chk("cfg.hold_end", 32'(cfg_grant), 32'(0));

    // sample and cfg request in the same idle cycle
    idle(2);
    cfg_req = 1'b1;
    cfg_addr = 6'h2A;
    sample_stb = 1'b1;
    follow(0, 0, 0, ch);
    tick();
    cfg_req = 1'b0;
    chk("cfg_after_done.grant", 32'(cfg_grant), 32'(1));
    chk("cfg_after_done.we", 32'(cmem_we), 32'(1));
    chk("cfg_after_done.addr", 32'(cmem_addr), 32'(6'h2A));
    tick();
    chk("cfg_after_done.off", 32'(cfg_grant), 32'(0));

    // second strobe 30 cycles into a sample
    idle(20);
    sample_stb = 1'b1;
    follow(30, 0, 0, ch);
    if (ch) follow(0, 0, 0, ch2);
    chk("busy_stb.overrun", 32'(overrun), 32'(exp_ovr));
    idle(2);
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_clr.overrun", 32'(overrun), 32'(0));

    // two strobes while busy; the lost one coincides with ovr_clr
    idle(5);
    sample_stb = 1'b1;
    follow(10, 20, 0, ch);
    if (ch) follow(0, 0, 0, ch2);
    chk("double_stb.overrun", 32'(overrun), 32'(1));
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    chk("double_stb.cleared", 32'(overrun), 32'(0));

    // randomized sample spacing with interleaved coefficient writes
    for (int r = 0; r < 6; r++) begin
      idle(int'($urandom_range(1, 120)));
      if ($urandom_range(0, 1) == 1) begin
        ra = 6'($urandom_range(0, 63));
        cfg_write(ra);
      end
      sample_stb = 1'b1;
      follow(0, 0, 0, ch);
    end

    // reset asserted 40 cycles into MAC
    idle(4);
    sample_stb = 1'b1;
    follow(0, 0, 41, ch);
    sample_stb = 1'b0;
    repeat (2) begin
      tick();
      check_all_zero("in_reset");
    end
    rst_n = 1'b1;
    idle(40);
    sample_stb = 1'b1;
    follow(0, 0, 0, ch);
    idle(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
